// File: rtl/sap1_cpu.sv
// SAP-1 educational CPU: six-state ring counter, W-bus datapath, fixed 16x8 program memory.
// Executes LDA/ADD/SUB/OUT/HLT from the built-in program and exposes all architectural state.
module sap1_cpu (
    input  logic        clk,
    input  logic        clrn,
    output logic [7:0]  bus,
    output logic [2:0]  counter,
    output logic [5:0]  counter_out,
    output logic [7:0]  display,
    output logic [7:0]  acc_reg,
    output logic [7:0]  breg,
    output logic [3:0]  input_mar,
    output logic [3:0]  ir_out,
    output logic [3:0]  pc_out,
    output logic [11:0] controlword
);

    localparam logic [2:0] T1 = 3'd0;
    localparam logic [2:0] T2 = 3'd1;
    localparam logic [2:0] T3 = 3'd2;
    localparam logic [2:0] T4 = 3'd3;
    localparam logic [2:0] T5 = 3'd4;
    localparam logic [2:0] T6 = 3'd5;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [11:0] CW_NOP      = 12'h3E3;
    localparam logic [11:0] CW_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] CW_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] CW_FETCH_T3 = 12'h263;
    localparam logic [11:0] CW_OPERAND  = 12'h1A3;
    localparam logic [11:0] CW_LDA_T5   = 12'h2C3;
    localparam logic [11:0] CW_LOADB_T5 = 12'h2E1;
    localparam logic [11:0] CW_ADD_T6   = 12'h3C7;
    localparam logic [11:0] CW_SUB_T6   = 12'h3CF;
    localparam logic [11:0] CW_OUT_T4   = 12'h3F2;

    logic [3:0] pc_q, pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] out_q, out_d;
    logic [2:0] t_q, t_d;
    logic       halted_q, halted_d;

    logic [7:0] ram_data;
    logic [7:0] alu_result;
    logic       halt_now;
    logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;

    // Program memory is never written, so it is a constant table indexed by the MAR.
    function automatic logic [7:0] program_rom(input logic [3:0] addr);
        logic [7:0] data;
        case (addr)
            4'h0:    data = 8'h09;
            4'h1:    data = 8'h1A;
            4'h2:    data = 8'h1B;
            4'h3:    data = 8'h2C;
            4'h4:    data = 8'hE0;
            4'h5:    data = 8'hF0;
            4'h9:    data = 8'h10;
            4'hA:    data = 8'h14;
            4'hB:    data = 8'h18;
            4'hC:    data = 8'h20;
            default: data = 8'h00;
        endcase
        return data;
    endfunction

    assign ram_data = program_rom(mar_q);

    always_comb begin : decode
        controlword = CW_NOP;
        if (!halted_q) begin
            unique case (t_q)
                T1: controlword = CW_FETCH_T1;
                T2: controlword = CW_FETCH_T2;
                T3: controlword = CW_FETCH_T3;
                T4: begin
                    if (ir_q[7:4] == OP_LDA || ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB)
                        controlword = CW_OPERAND;
                    else if (ir_q[7:4] == OP_OUT)
                        controlword = CW_OUT_T4;
                end
                T5: begin
                    if (ir_q[7:4] == OP_LDA)
                        controlword = CW_LDA_T5;
                    else if (ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB)
                        controlword = CW_LOADB_T5;
                end
                T6: begin
                    if (ir_q[7:4] == OP_ADD)
                        controlword = CW_ADD_T6;
                    else if (ir_q[7:4] == OP_SUB)
                        controlword = CW_SUB_T6;
                end
                default: controlword = CW_NOP;
            endcase
        end
    end

    assign {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n} = controlword;

    assign alu_result = su ? (a_q - b_q) : (a_q + b_q);

    always_comb begin : w_bus
        bus = 8'h00;
        if (ep)
            bus = {4'h0, pc_q};
        else if (!ce_n)
            bus = ram_data;
        else if (!ei_n)
            bus = {4'h0, ir_q[3:0]};
        else if (ea)
            bus = a_q;
        else if (eu)
            bus = alu_result;
    end

    // HLT takes effect at the edge ending its T4; the ring counter stays parked there.
    assign halt_now = !halted_q && (t_q == T4) && (ir_q[7:4] == OP_HLT);

    always_comb begin : next_state
        pc_d     = cp    ? pc_q + 4'd1 : pc_q;
        mar_d    = !lm_n ? bus[3:0]    : mar_q;
        ir_d     = !li_n ? bus         : ir_q;
        a_d      = !la_n ? bus         : a_q;
        b_d      = !lb_n ? bus         : b_q;
        out_d    = !lo_n ? bus         : out_q;
        halted_d = halted_q | halt_now;
        if (halted_q || halt_now)
            t_d = t_q;
        else if (t_q >= T6)
            t_d = T1;
        else
            t_d = t_q + 3'd1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_q     <= 4'h0;
            mar_q    <= 4'h0;
            ir_q     <= 8'h00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            out_q    <= 8'h00;
            t_q      <= T1;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            t_q      <= t_d;
            halted_q <= halted_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ring
            assign counter_out[gi] = (t_q == 3'(gi));
        end
    endgenerate

    assign counter   = t_q;
    assign display   = out_q;
    assign acc_reg   = a_q;
    assign breg      = b_q;
    assign input_mar = mar_q;
    assign ir_out    = ir_q[7:4];
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_sap1_cpu.sv
// Bench for sap1_cpu: instruction-level reference model checked every cycle,
// fixed-program milestones, and randomly timed asynchronous resets.
module tb_sap1_cpu;

    logic        clk  = 1'b0;
    logic        clrn = 1'b1;
    logic [7:0]  bus;
    logic [2:0]  counter;
    logic [5:0]  counter_out;
    logic [7:0]  display;
    logic [7:0]  acc_reg;
    logic [7:0]  breg;
    logic [3:0]  input_mar;
    logic [3:0]  ir_out;
    logic [3:0]  pc_out;
    logic [11:0] controlword;

    sap1_cpu dut (
        .clk(clk), .clrn(clrn), .bus(bus), .counter(counter),
        .counter_out(counter_out), .display(display), .acc_reg(acc_reg),
        .breg(breg), .input_mar(input_mar), .ir_out(ir_out),
        .pc_out(pc_out), .controlword(controlword)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: architectural registers plus which micro-step (0..5) comes next.
    logic [7:0] mem [16];
    int         m_t    = 0;
    logic [3:0] m_pc   = 0;
    logic [3:0] m_mar  = 0;
    logic [7:0] m_ir   = 0;
    logic [7:0] m_a    = 0;
    logic [7:0] m_b    = 0;
    logic [7:0] m_out  = 0;
    bit         m_halt = 0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h1B; mem[3] = 8'h2C;
        mem[4] = 8'hE0; mem[5] = 8'hF0;
        mem[9] = 8'h10; mem[10] = 8'h14; mem[11] = 8'h18; mem[12] = 8'h20;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cw();
        int op = int'(m_ir[7:4]);
        if (m_halt) return 'h3E3;
        case (m_t)
            0: return 'h5E3;
            1: return 'hBE3;
            2: return 'h263;
            3: return (op <= 2) ? 'h1A3 : (op == 14) ? 'h3F2 : 'h3E3;
            4: return (op == 0) ? 'h2C3 : (op == 1 || op == 2) ? 'h2E1 : 'h3E3;
            5: return (op == 1) ? 'h3C7 : (op == 2) ? 'h3CF : 'h3E3;
            default: return 'h3E3;
        endcase
    endfunction

    function automatic int exp_bus();
        int op = int'(m_ir[7:4]);
        if (m_halt) return 0;
        case (m_t)
            0: return int'(m_pc);
            2: return int'(mem[m_mar]);
            3: return (op <= 2) ? int'(m_ir[3:0]) : (op == 14) ? int'(m_a) : 0;
            4: return (op <= 2) ? int'(mem[m_mar]) : 0;
            5: return (op == 1) ? int'(8'(m_a + m_b)) : (op == 2) ? int'(8'(m_a - m_b)) : 0;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_t = 0; m_pc = 0; m_mar = 0; m_ir = 0;
            m_a = 0; m_b = 0; m_out = 0; m_halt = 0;
        end else if (!m_halt) begin
            case (m_t)
                0: m_mar = m_pc;
                1: m_pc = m_pc + 4'd1;
                2: m_ir = mem[m_mar];
                3: case (m_ir[7:4])
                       4'h0, 4'h1, 4'h2: m_mar = m_ir[3:0];
                       4'hE: m_out = m_a;
                       4'hF: m_halt = 1;
                       default: ;
                   endcase
                4: case (m_ir[7:4])
                       4'h0: m_a = mem[m_mar];
                       4'h1, 4'h2: m_b = mem[m_mar];
                       default: ;
                   endcase
                5: case (m_ir[7:4])
                       4'h1: m_a = m_a + m_b;
                       4'h2: m_a = m_a - m_b;
                       default: ;
                   endcase
                default: ;
            endcase
            if (!m_halt) m_t = (m_t == 5) ? 0 : m_t + 1;
        end
    end

    always @(negedge clk) begin
        check("bus",         int'(bus),         exp_bus());
        check("counter",     int'(counter),     m_t);
        check("counter_out", int'(counter_out), 1 << m_t);
        check("controlword", int'(controlword), exp_cw());
        check("pc_out",      int'(pc_out),      int'(m_pc));
        check("input_mar",   int'(input_mar),   int'(m_mar));
        check("ir_out",      int'(ir_out),      int'(m_ir[7:4]));
        check("acc_reg",     int'(acc_reg),     int'(m_a));
        check("breg",        int'(breg),        int'(m_b));
        check("display",     int'(display),     int'(m_out));
    end

    task automatic release_reset();
        @(posedge clk);
        #2;
        clrn = 1'b1;
        cyc  = -1;
    endtask

    // Cycle c is the state seen after c rising edges since reset release.
    task automatic run_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_counter"}, int'(counter), 0);
        check({tag, "_pc"},      int'(pc_out), 0);
        check({tag, "_mar"},     int'(input_mar), 0);
        check({tag, "_ir"},      int'(ir_out), 0);
        check({tag, "_acc"},     int'(acc_reg), 0);
        check({tag, "_breg"},    int'(breg), 0);
        check({tag, "_display"}, int'(display), 0);
    endtask

    initial begin
        #1 clrn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_ring", int'(counter_out), 6'b000001);

        release_reset();
        run_to(0);
        check("t1_cw", int'(controlword), 'h5E3);
        run_to(1);
        check("first_ring", int'(counter_out), 6'b000010);
        check("first_mar",  int'(input_mar), 0);
        run_to(6);
        check("lda_acc", int'(acc_reg), 'h10);
        check("lda_pc",  int'(pc_out), 1);
        check("lda_ir",  int'(ir_out), 0);
        run_to(11);
        check("adda_t6_cw", int'(controlword), 'h3C7);
        run_to(12);
        check("adda_acc", int'(acc_reg), 'h24);
        check("adda_b",   int'(breg), 'h14);
        run_to(17);
        check("addb_t6_cw", int'(controlword), 'h3C7);
        run_to(18);
        check("addb_acc", int'(acc_reg), 'h3C);
        check("addb_b",   int'(breg), 'h18);
        run_to(23);
        check("sub_t6_cw", int'(controlword), 'h3CF);
        run_to(24);
        check("sub_acc", int'(acc_reg), 'h1C);
        check("sub_b",   int'(breg), 'h20);
        run_to(28);
        check("out_display", int'(display), 'h1C);
        run_to(33);
        check("hlt_counter", int'(counter), 3);
        for (int k = 0; k < 20; k++) begin
            run_to(34 + k);
            check("halt_counter", int'(counter), 3);
            check("halt_cw",      int'(controlword), 'h3E3);
            check("halt_acc",     int'(acc_reg), 'h1C);
            check("halt_display", int'(display), 'h1C);
            check("halt_pc",      int'(pc_out), 6);
            check("halt_b",       int'(breg), 'h20);
        end

        // Reset pulse in the middle of ADD B (T5), then the program must rerun.
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        run_to(16);
        check("addb_t5_counter", int'(counter), 4);
        #2 clrn = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(posedge clk);
        release_reset();
        run_to(28);
        check("rerun_display", int'(display), 'h1C);
        run_to(33);
        check("rerun_halt", int'(counter), 3);

        // Randomly timed resets; the per-cycle model comparison covers these.
        for (int k = 0; k < 10; k++) begin
            clrn = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            release_reset();
            run_to(int'($urandom_range(2, 60)));
            #($urandom_range(1, 4));
        end
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        run_to(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap1_cpu.md
SAP1_CPU -- requirements
Module: sap1_cpu

Interface
REQ-001 Parameters: none; the block has one clock and reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 bus  output  8  internal W-bus value; 8'h00 when no source enabled.
REQ-005 counter  output  3  current T-state code: T1=0, T2=1, T3=2, T4=3, T5=4, T6=5.
REQ-006 counter_out  output  6  one-hot T-state: bit0=T1 ... bit5=T6.
REQ-007 display  output  8  output register.
REQ-008 acc_reg  output  8  accumulator A.
REQ-009 breg  output  8  B register.
REQ-010 input_mar  output  4  memory address register.
REQ-011 ir_out  output  4  instruction-register opcode nibble, IR[7:4].
REQ-012 pc_out  output  4  program counter.
REQ-013 controlword  output  12  combinational control word; bit11..0 = Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n; inactive value 12'h3E3.

Function
REQ-014 Internal 16x8 RAM is addressed by the MAR; IR is 8 bits, with IR[3:0] as the operand address.
REQ-015 Bus sources: Ep puts {4'h0,PC}; CE_n low puts RAM[MAR]; Ei_n low puts {4'h0,IR[3:0]}; Ea puts A; Eu puts the ALU result.
REQ-016 At most one bus source is active per state.
REQ-017 Loads take effect at the rising edge ending the state: Lm_n low loads MAR<=bus[3:0]; Li_n low loads IR; La_n low loads A; Lb_n low loads B; Lo_n low loads display.
REQ-018 Cp high increments PC at the rising edge ending the state; PC wraps 15->0.
REQ-019 ALU result is 8-bit modulo 256: A+B when Su=0, A-B when Su=1; no flags are produced.
REQ-020 Ring counter sequence is T1->T2->T3->T4->T5->T6->T1, advancing one state per clock.
REQ-021 Fetch control words: T1 = 12'h5E3 (Ep, Lm_n); T2 = 12'hBE3 (Cp); T3 = 12'h263 (CE_n, Li_n).
REQ-022 LDA (opcode 0000): T4 = 12'h1A3 (Ei_n, Lm_n); T5 = 12'h2C3 (CE_n, La_n); T6 = 12'h3E3 (no operation).
REQ-023 ADD (opcode 0001): T4 = 12'h1A3; T5 = 12'h2E1 (CE_n, Lb_n); T6 = 12'h3C7 (La_n, Eu).
REQ-024 SUB (opcode 0010): T4 = 12'h1A3; T5 = 12'h2E1; T6 = 12'h3CF (La_n, Su, Eu).
REQ-025 OUT (opcode 1110): T4 = 12'h3F2 (Ea, Lo_n); T5 and T6 = 12'h3E3.
REQ-026 HLT (opcode 1111): in T4 the halted flag is set.
REQ-027 Once halted, the counter freezes at T4, controlword = 12'h3E3, and no register changes until reset.
REQ-028 Any other opcode executes as a no-operation for T4 through T6.
REQ-029 Cycle checks: state T1 implies next-cycle input_mar equals the T1 bus[3:0]; T2 implies next-cycle pc_out = previous pc_out+1; T3 implies IR loads RAM[MAR] at the next edge.

Reset
REQ-030 While clrn=0, asynchronously: PC=0, MAR=0, IR=0, A=0, B=0, display=0, counter=T1, halted=0.
REQ-031 A reset asserted mid-instruction aborts the instruction; execution restarts with fetch from address 0 after release.
REQ-032 RAM is initialized to the fixed program: 0:09h (LDA 9), 1:1Ah (ADD A), 2:1Bh (ADD B), 3:2Ch (SUB C), 4:E0h (OUT), 5:F0h (HLT), 9:10h, A:14h, B:18h, C:20h; all other locations 00h.
REQ-033 RAM contents are not altered by execution.

Verification
REQ-034 Release clrn, then one clock -> counter_out=000010, input_mar=0, controlword in T1 was 12'h5E3.
REQ-035 First instruction (LDA 9) completes -> acc_reg=10h, pc_out=1, ir_out=0.
REQ-036 After ADD A then ADD B -> acc_reg=24h then 3Ch, with breg=14h then 18h; T6 controlword = 12'h3C7.
REQ-037 SUB C -> acc_reg=1Ch, breg=20h; T6 controlword = 12'h3CF.
REQ-038 OUT then HLT -> display=1Ch; counter stays T4 and all registers hold for 20 further clocks.
REQ-039 Pulse clrn low during ADD B T5 -> all registers 0 immediately; the program reruns to display=1Ch.
